// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, route-direction encodings, decode helpers.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_S = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    localparam logic [3:0] DIR_N    = 4'b0100;
    localparam logic [3:0] DIR_E    = 4'b0010;
    localparam logic [3:0] DIR_S    = 4'b0001;
    localparam logic [3:0] DIR_W    = 4'b1000;
    localparam logic [3:0] DIR_L    = 4'b0000;
    localparam logic [3:0] DIR_NONE = 4'b1111;

    typedef struct packed {
        logic       ok;
        logic [2:0] port;
    } dir_dec_t;

    // Map a route-compute direction code to an output port; ok=0 for any unknown code.
    function automatic dir_dec_t dir_decode(input logic [3:0] dir);
        dir_dec_t d;
        d.ok   = 1'b1;
        d.port = P_L;
        case (dir)
            DIR_N:   d.port = P_N;
            DIR_E:   d.port = P_E;
            DIR_S:   d.port = P_S;
            DIR_W:   d.port = P_W;
            DIR_L:   d.port = P_L;
            default: d.ok   = 1'b0;
        endcase
        return d;
    endfunction

    // Index of the set bit in a one-hot grant vector (0 when empty).
    function automatic logic [2:0] onehot_to_idx(input logic [4:0] oh);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (oh[k]) r = 3'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-way round-robin arbiter: searches ptr, ptr+1, ... modulo 5 and
// proposes the pointer value one past the winner.
module rr_arb5 import noc_pkg::*; (
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] gnt,
    output logic [2:0] ptr_next
);

    int         idx;
    logic [2:0] idx3;
    logic       found;

    // Pick the first requester at or after the pointer, wrapping 4 -> 0.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        idx3     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idx3 = 3'(idx);
            if (!found && req[idx3]) begin
                found     = 1'b1;
                gnt[idx3] = 1'b1;
                ptr_next  = (idx3 == 3'(NUM_PORTS - 1)) ? 3'd0 : idx3 + 3'd1;
            end
        end
    end

endmodule

// File: rtl/sw_alloc_11.sv
// Switch allocator for a 5-port mesh router with credit-based flow control.
// Optional feature: define SA_PRESSURE_OUT_EN to add the per-output
// pressure_out port (DEPTH minus current credit, registered).
module sw_alloc_11 import noc_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic        sa_clk,
    input  logic        rst_n,
    input  logic [4:0]  req_valid,
    input  logic [19:0] req_dir,
    input  logic [4:0]  credit_ret,
    output logic [4:0]  grant,
    output logic [4:0]  out_valid,
    output logic [14:0] out_sel,
    output logic        dir_err
`ifdef SA_PRESSURE_OUT_EN
    ,
    output logic [5*(WIDTH+1)-1:0] pressure_out
`endif
);

    localparam int            CW       = WIDTH + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    dir_dec_t      dec         [NUM_PORTS];
    logic [4:0]    legal;
    logic [4:0]    arb_req     [NUM_PORTS];
    logic [4:0]    arb_gnt     [NUM_PORTS];
    logic [2:0]    ptr         [NUM_PORTS];
    logic [2:0]    ptr_next    [NUM_PORTS];
    logic [CW-1:0] credit      [NUM_PORTS];
    logic [CW-1:0] credit_next [NUM_PORTS];
    logic [4:0]    out_gnt;
    logic [4:0]    cred_ovf;
    logic          err_next;

    // Decode each input's direction; mesh U-turns are illegal, local loopback is allowed.
    always_comb begin
        legal = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dec[i]   = dir_decode(req_dir[4*i +: 4]);
            legal[i] = dec[i].ok && ((dec[i].port != 3'(i)) || (dec[i].port == P_L));
        end
    end

    // Build per-output request vectors; an output with zero credit sees no requests.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            arb_req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                arb_req[o][i] = req_valid[i] && legal[i] && (dec[i].port == 3'(o))
                                && (credit[o] != '0);
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arb5 u_arb (
            .req      (arb_req[o]),
            .ptr      (ptr[o]),
            .gnt      (arb_gnt[o]),
            .ptr_next (ptr_next[o])
        );
    end

    // Merge output grants into per-input grants; each input targets one output only.
    always_comb begin
        grant   = '0;
        out_gnt = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_gnt[o] = |arb_gnt[o];
            grant      = grant | arb_gnt[o];
        end
        grant = grant & {5{rst_n}};
    end

    // Credit bookkeeping: grant consumes, return refunds, both together cancel; saturate at DEPTH.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            credit_next[o] = credit[o];
            cred_ovf[o]    = 1'b0;
            case ({out_gnt[o], credit_ret[o]})
                2'b10:   credit_next[o] = credit[o] - CRED_ONE;
                2'b01: begin
                    if (credit[o] == CRED_MAX) cred_ovf[o]    = 1'b1;
                    else                       credit_next[o] = credit[o] + CRED_ONE;
                end
                default: credit_next[o] = credit[o];
            endcase
        end
        err_next = (|(req_valid & ~legal)) || (|cred_ovf);
    end

    // Register credits, pointers, crossbar selects and the error pulse.
    always_ff @(posedge sa_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these per-output arrays are a handful of flops, not a RAM, so resetting them in a loop is intended.
            for (int o = 0; o < NUM_PORTS; o++) begin
                credit[o] <= CRED_MAX;
                ptr[o]    <= '0;
            end
            out_valid <= '0;
            out_sel   <= '0;
            dir_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            for (int o = 0; o < NUM_PORTS; o++) begin
                credit[o] <= credit_next[o];
                if (out_gnt[o]) begin
                    ptr[o]           <= ptr_next[o];
                    out_sel[3*o +: 3] <= onehot_to_idx(arb_gnt[o]);
                end
            end
            out_valid <= out_gnt;
            dir_err   <= err_next;
        end
    end

`ifdef SA_PRESSURE_OUT_EN
    // Expose downstream occupancy (DEPTH minus credit) aligned with the credit register.
    always_ff @(posedge sa_clk or negedge rst_n) begin
        if (!rst_n) begin
            pressure_out <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                pressure_out[CW*o +: CW] <= CRED_MAX - credit_next[o];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sw_alloc_11.sv
// Directed self-checking bench for sw_alloc_11 (default DEPTH=8, WIDTH=3).
module tb_sw_alloc_11;

    localparam logic [3:0] D_N    = 4'b0100;
    localparam logic [3:0] D_E    = 4'b0010;
    localparam logic [3:0] D_S    = 4'b0001;
    localparam logic [3:0] D_L    = 4'b0000;
    localparam logic [3:0] D_NONE = 4'b1111;

    logic        sa_clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [19:0] req_dir;
    logic [4:0]  credit_ret;
    logic [4:0]  grant;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic        dir_err;
`ifdef SA_PRESSURE_OUT_EN
    logic [19:0] pressure_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    sw_alloc_11 dut (
        .sa_clk     (sa_clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_dir    (req_dir),
        .credit_ret (credit_ret),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .dir_err    (dir_err)
`ifdef SA_PRESSURE_OUT_EN
        ,
        .pressure_out (pressure_out)
`endif
    );

    always #5 sa_clk = ~sa_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge sa_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] rot_exp [6];
        rot_exp[0] = 5'b00001; rot_exp[1] = 5'b00010; rot_exp[2] = 5'b00100;
        rot_exp[3] = 5'b01000; rot_exp[4] = 5'b10000; rot_exp[5] = 5'b00001;

        // ---- reset: a legal request must still see no grant
        rst_n      = 1'b0;
        req_valid  = 5'b00001;
        req_dir    = '0;
        req_dir[3:0] = D_S;
        credit_ret = '0;
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        repeat (2) @(posedge sa_clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);
        check("rst_dir_err", 32'(dir_err), 32'h0);
        req_valid = '0;
        @(negedge sa_clk);
        rst_n = 1'b1;
        tick();

        // ---- N and W both request S: N first, then W
        req_dir = '0;
        req_dir[3:0]   = D_S;
        req_dir[15:12] = D_S;
        req_valid = 5'b01001;
        #1;
        check("t1_grant_n", 32'(grant), 32'h01);
        tick();
        req_valid = 5'b01000;
        #1;
        check("t1_out_valid_s", 32'(out_valid), 32'h04);
        check("t1_sel_n", 32'(out_sel[8:6]), 32'd0);
        check("t1_grant_w", 32'(grant), 32'h08);
        tick();
        req_valid = '0;
        #1;
        check("t1_sel_w", 32'(out_sel[8:6]), 32'd3);
        check("t1_out_valid_s2", 32'(out_valid), 32'h04);
        check("t1_no_grant", 32'(grant), 32'h0);
        check("t1_no_err", 32'(dir_err), 32'h0);
        tick();
        check("t1_out_valid_idle", 32'(out_valid), 32'h0);
        check("t1_sel_hold", 32'(out_sel[8:6]), 32'd3);

        // ---- L -> E eight times drains the E credit, ninth blocked
        req_dir = '0;
        req_dir[19:16] = D_E;
        req_valid = 5'b10000;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("t2_grant_%0d", k), 32'(grant), 32'h10);
            tick();
        end
        check("t2_out_valid_e", 32'(out_valid), 32'h02);
        check("t2_sel_e", 32'(out_sel[5:3]), 32'd4);
        #1;
        check("t2_blocked", 32'(grant), 32'h0);
        tick();
        credit_ret = 5'b00010;
        #1;
        check("t2_ret_not_usable", 32'(grant), 32'h0);
        tick();
        credit_ret = '0;
        check("t2_out_valid_blocked", 32'(out_valid), 32'h0);
        #1;
        check("t2_grant_after_ret", 32'(grant), 32'h10);
        tick();
        req_valid = '0;

        // ---- credit return and grant on E in the same cycle: credit stays at 1
        credit_ret = 5'b00010;
        tick();
        req_valid = 5'b10000;
        #1;
        check("t3_grant_with_ret", 32'(grant), 32'h10);
        tick();
        credit_ret = '0;
        req_valid  = '0;
        tick();
        req_valid = 5'b10000;
        #1;
        check("t3_credit_kept", 32'(grant), 32'h10);
        tick();
        #1;
        check("t3_credit_empty", 32'(grant), 32'h0);
        req_valid = '0;
        tick();

        // ---- credit return on full output N overflows
        credit_ret = 5'b00001;
        tick();
        credit_ret = '0;
        check("ovf_err", 32'(dir_err), 32'h1);
        tick();
        check("ovf_err_clear", 32'(dir_err), 32'h0);

        // ---- E U-turn and L with DIR_NONE are ignored and flagged
        req_dir = '0;
        req_dir[7:4]   = D_E;
        req_dir[19:16] = D_NONE;
        req_valid = 5'b10010;
        #1;
        check("t4_no_grant", 32'(grant), 32'h0);
        tick();
        req_valid = '0;
        check("t4_dir_err", 32'(dir_err), 32'h1);
        check("t4_out_valid", 32'(out_valid), 32'h0);
        tick();
        check("t4_dir_err_clear", 32'(dir_err), 32'h0);

        // ---- all inputs request L continuously: rotation 0,1,2,3,4,0
        req_dir   = '0;
        req_valid = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("t5_grant_%0d", k), 32'(grant), 32'(rot_exp[k]));
            tick();
            check($sformatf("t5_sel_%0d", k), 32'(out_sel[14:12]), 32'(k % 5));
            check($sformatf("t5_ov_%0d", k), 32'(out_valid), 32'h10);
        end
        check("t5_no_err", 32'(dir_err), 32'h0);

        // ---- reset during an active grant
        #1;
        check("t6_pre_grant", 32'(grant), 32'h02);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_grant_drop", 32'(grant), 32'h0);
        check("t6_out_valid", 32'(out_valid), 32'h0);
        check("t6_out_sel", 32'(out_sel), 32'h0);
        @(posedge sa_clk);
        @(negedge sa_clk);
        rst_n = 1'b1;
        #1;
        check("t6_ptr_reset", 32'(grant), 32'h01);
        req_dir = '0;
        req_dir[19:16] = D_E;
        req_valid = 5'b10000;
        #1;
        check("t6_credit_restored", 32'(grant), 32'h10);
        tick();
        req_valid = '0;
        check("t6_out_valid_e", 32'(out_valid), 32'h02);
        check("t6_sel_e", 32'(out_sel[5:3]), 32'd4);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
